bk_addsub_seq: RTL and testbench

Parametrised multi-cycle adder/subtractor for the modular-multiplication datapath. It processes a WIDTH-bit operand pair one CHUNK-bit slice per cycle through a Brent-Kung prefix adder, carrying the inter-slice carry in a register. It adds a subtract mode, honours the external carry-in and uses a clean start/busy/done handshake. Result registers hold their value until the next accepted operation. It sits wherever the reduction loop needs wide add/sub without a full-width carry path.

---
 rtl/bk_pkg.sv | 23 ++
 rtl/bk_prefix_adder.sv | 67 ++++++
 rtl/bk_addsub_seq.sv | 153 +++++++++++++++
 tb/tb_bk_addsub_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
`timescale 1ns/1ps
// bk_pkg
// Shared definitions for the sequential Brent-Kung adder/subtractor:
//   bk_state_t  - control FSM encoding (IDLE, RUN, DONE)
//   BK_WIDTH    - default operand width
//   BK_CHUNK    - default slice width processed per cycle
//   bk_idx_w()  - width of a slice counter for n slices (never below 1 bit)
package bk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bk_state_t;

  localparam int BK_WIDTH = 256;
  localparam int BK_CHUNK = 16;

  function automatic int bk_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bk_prefix_adder.sv
`timescale 1ns/1ps
// bk_prefix_adder
// Combinational N-bit Brent-Kung prefix adder with carry-in.
// Ports:
//   a, b   in  [N-1:0]  addends
//   cin    in  1        carry into bit 0
//   s      out [N-1:0]  sum
//   cout   out 1        carry out of bit N-1
//   c_msb  out 1        carry into bit N-1 (signed overflow tap)
// N must be a power of two, at least 2.
module bk_prefix_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [N-1:0] gen_bit;
  logic [N-1:0] prop_bit;
  logic [N-1:0] grp_g;
  logic [N-1:0] grp_p;
  logic [N:0]   carry;

  assign gen_bit  = a & b;
  assign prop_bit = a ^ b;

  // Group generate/propagate for prefixes [i:0]. The up-sweep builds a
  // reduction tree over power-of-two spans; the down-sweep fills the
  // remaining positions from the nearest completed prefix to their left.
  always_comb begin
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    gg = gen_bit;
    pp = prop_bit;
    for (int d = 1; d < N; d = d * 2) begin
      for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = N / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    grp_g = gg;
    grp_p = pp;
  end

  // Carry-in is folded in after the tree: c[i+1] = G[i:0] | P[i:0]&cin.
  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      carry[i+1] = grp_g[i] | (grp_p[i] & cin);
    end
  end

  assign s     = prop_bit ^ carry[N-1:0];
  assign cout  = carry[N];
  assign c_msb = carry[N-1];

endmodule

// File: rtl/bk_addsub_seq.sv
`timescale 1ns/1ps
// bk_addsub_seq
// Multi-cycle WIDTH-bit adder/subtractor. One CHUNK-bit slice is summed per
// cycle through a single Brent-Kung prefix adder; the inter-slice carry is
// held in a register. Subtraction is A + ~B + ~Ci.
// Optional feature macro: BK_ADDSUB_OVF_EN adds the signed-overflow output.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only when idle
//   sub    in   0: A+B+Ci, 1: A-B-Ci
//   A, B   in   [WIDTH-1:0] operands, sampled with start
//   Ci     in   carry-in / borrow-in, sampled with start
//   S      out  [WIDTH-1:0] registered result, updated only on done
//   Co     out  carry-out (subtract: 1 = no borrow)
//   busy   out  operation in flight (start accepted through DONE cycle)
//   done   out  one-cycle pulse coinciding with S/Co update
//   ovf    out  signed overflow (only with BK_ADDSUB_OVF_EN)
module bk_addsub_seq
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH,
  parameter int CHUNK = BK_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             busy,
  output logic             done
`ifdef BK_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = bk_idx_w(NCHUNK);

  if ((WIDTH % CHUNK) != 0 || CHUNK < 2 || (CHUNK & (CHUNK - 1)) != 0) begin : g_bad_param
    $error("bk_addsub_seq: CHUNK must be a power of two >= 2 dividing WIDTH");
  end

  bk_state_t        state;
  logic [IDX_W-1:0] idx;
  logic             c;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_co;
  logic             last;
  logic             accept;

  assign accept = (state == IDLE) && start;
  assign last   = (idx == IDX_W'(NCHUNK - 1));

  // Operands are shifted right each RUN cycle so the active slice is always
  // the low CHUNK bits; the accumulator fills from the top, so after NCHUNK
  // slices it holds the full result in place without any indexed writes.
  assign acc_next = (acc >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));

`ifdef BK_ADDSUB_OVF_EN
  logic c_msb;
`else
  logic c_msb_unused;
`endif

  bk_prefix_adder #(
    .N(CHUNK)
  ) u_adder (
    .a    (opa[CHUNK-1:0]),
    .b    (opb[CHUNK-1:0]),
    .cin  (c),
    .s    (slice_sum),
    .cout (slice_co),
`ifdef BK_ADDSUB_OVF_EN
    .c_msb(c_msb)
`else
    .c_msb(c_msb_unused)
`endif
  );

  // Datapath: operand and accumulator registers need no reset; they are
  // loaded on accept and fully overwritten before being observed on S.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa <= A;
      opb <= sub ? ~B : B;
    end else if (state == RUN) begin
      opa <= opa >> CHUNK;
      opb <= opb >> CHUNK;
      acc <= acc_next;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      c     <= 1'b0;
      S     <= '0;
      Co    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef BK_ADDSUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Borrow-in becomes carry-in of the complemented form.
            c     <= Ci ^ sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          c   <= slice_co;
          idx <= idx + 1'b1;
          if (last) begin
            S     <= acc_next;
            Co    <= slice_co;
`ifdef BK_ADDSUB_OVF_EN
            ovf   <= slice_co ^ c_msb;
`endif
            done  <= 1'b1;
            idx   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bk_addsub_seq.sv
`timescale 1ns/1ps
// tb_bk_addsub_seq
// Directed checks of the default 256/16 configuration and a 64/8 instance.
module tb_bk_addsub_seq;

  logic clk;
  logic rst_n;

  logic         start0, sub0, Ci0;
  logic [255:0] A0, B0, S0;
  logic         Co0, busy0, done0;

  logic         start1, sub1, Ci1;
  logic [63:0]  A1, B1, S1;
  logic         Co1, busy1, done1;
`ifdef BK_ADDSUB_OVF_EN
  logic         ovf0, ovf1;
`endif

  int nchk = 0;
  int nerr = 0;
  int dcnt0 = 0;
  int dcnt1 = 0;

  bk_addsub_seq #(.WIDTH(256), .CHUNK(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub0),
    .A(A0), .B(B0), .Ci(Ci0), .S(S0), .Co(Co0), .busy(busy0), .done(done0)
`ifdef BK_ADDSUB_OVF_EN
    , .ovf(ovf0)
`endif
  );

  bk_addsub_seq #(.WIDTH(64), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1),
    .A(A1), .B(B1), .Ci(Ci1), .S(S1), .Co(Co1), .busy(busy1), .done(done1)
`ifdef BK_ADDSUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done0) dcnt0++;
    if (done1) dcnt1++;
  end

  task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one op on the 256-bit instance. restart_at >= 1 re-asserts start
  // (with different operands) just before edge E(restart_at+1).
  task automatic op0(input string tag, input logic [255:0] a, input logic [255:0] b,
                     input logic sb, input logic ci,
                     input logic [255:0] exp_s, input logic exp_co, input int restart_at);
    logic [255:0] s_prev;
    int cyc, d0;
    bit stable, bsy;
    @(negedge clk);
    A0 = a; B0 = b; sub0 = sb; Ci0 = ci; start0 = 1'b1;
    s_prev = S0; d0 = dcnt0;
    @(posedge clk); #1;
    start0 = 1'b0; A0 = ~a; B0 = '0; sub0 = ~sb; Ci0 = ~ci;
    cyc = 0; stable = 1'b1; bsy = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (!busy0) bsy = 1'b0;
      if (done0) break;
      if (S0 !== s_prev) stable = 1'b0;
      if (cyc == restart_at) begin start0 = 1'b1; A0 = 256'd12345; B0 = 256'd1; end
      if (cyc == restart_at + 1) start0 = 1'b0;
      if (cyc > 40) break;
    end
    chk({tag, " latency"}, 257'(cyc), 257'd16);
    chk({tag, " S"}, {1'b0, S0}, {1'b0, exp_s});
    chk({tag, " Co"}, 257'(Co0), 257'(exp_co));
    chk({tag, " S held"}, 257'(stable), 257'd1);
    chk({tag, " busy"}, 257'(bsy), 257'd1);
    @(posedge clk); #1;
    chk({tag, " done drop"}, 257'(done0), 257'd0);
    chk({tag, " busy drop"}, 257'(busy0), 257'd0);
    chk({tag, " done pulses"}, 257'(dcnt0 - d0), 257'd1);
  endtask

  task automatic op1(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic sb, input logic ci,
                     input logic [63:0] exp_s, input logic exp_co, input logic exp_ovf);
    int cyc;
    @(negedge clk);
    A1 = a; B1 = b; sub1 = sb; Ci1 = ci; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (done1 || cyc > 30) break;
    end
    chk({tag, " latency"}, 257'(cyc), 257'd8);
    chk({tag, " S"}, 257'(S1), 257'(exp_s));
    chk({tag, " Co"}, 257'(Co1), 257'(exp_co));
`ifdef BK_ADDSUB_OVF_EN
    chk({tag, " ovf"}, 257'(ovf1), 257'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("note: ovf expectation undefined for %s", tag);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    logic [255:0] ra, rb;
    logic [256:0] model;
    logic rs, rc;
    int d0;

    rst_n = 1'b0;
    start0 = 1'b0; sub0 = 1'b0; Ci0 = 1'b0; A0 = '0; B0 = '0;
    start1 = 1'b0; sub1 = 1'b0; Ci1 = 1'b0; A1 = '0; B1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset S", {1'b0, S0}, 257'd0);
    chk("reset Co", 257'(Co0), 257'd0);
    chk("reset busy", 257'(busy0), 257'd0);
    chk("reset done", 257'(done0), 257'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op0("allones+1", {256{1'b1}}, 256'd1, 1'b0, 1'b0, 256'd0, 1'b1, -1);
    op0("5-7", 256'd5, 256'd7, 1'b1, 1'b0, ~256'd1, 1'b0, -1);
    op0("7-5", 256'd7, 256'd5, 1'b1, 1'b0, 256'd2, 1'b1, -1);
    op0("0+0+1", 256'd0, 256'd0, 1'b0, 1'b1, 256'd1, 1'b0, -1);
    op0("3-1-1", 256'd3, 256'd1, 1'b1, 1'b1, 256'd1, 1'b1, -1);

    // Second start during RUN must be ignored: one done, first op's result.
    d0 = dcnt0;
    op0("handshake", 256'd1000, 256'd24, 1'b0, 1'b0, 256'd1024, 1'b0, 4);
    repeat (20) @(posedge clk);
    #1;
    chk("handshake no rerun", 257'(dcnt0 - d0), 257'd1);
    chk("handshake idle", 257'(busy0), 257'd0);
    chk("handshake S kept", {1'b0, S0}, 257'd1024);

    // Reset in the middle of an operation.
    @(negedge clk);
    A0 = 256'd9; B0 = 256'd9; sub0 = 1'b0; Ci0 = 1'b0; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst S", {1'b0, S0}, 257'd0);
    chk("midrst Co", 257'(Co0), 257'd0);
    chk("midrst busy", 257'(busy0), 257'd0);
    chk("midrst done", 257'(done0), 257'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op0("after rst", 256'd100, 256'd23, 1'b0, 1'b0, 256'd123, 1'b0, -1);

    // Random add/sub against full-width arithmetic.
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 8; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      rs = i[0];
      rc = 1'($urandom_range(0, 1));
      if (rs) model = {1'b0, ra} - {1'b0, rb} - 257'(rc) + {1'b1, 256'd0};
      else    model = {1'b0, ra} + {1'b0, rb} + 257'(rc);
      op0("random", ra, rb, rs, rc, model[255:0], model[256], -1);
    end

    op1("w64 ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
        64'h8000_0000_0000_0000, 1'b0, 1'b1);
    op1("w64 min-1", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0,
        64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    op1("w64 0-0", 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    chk("w64 done pulses", 257'(dcnt1), 257'd3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
